proc_ctrl: RTL and testbench
============================

# proc_ctrl

Control-unit sequencer for the simple 9-bit processor. It latches an instruction word from DIN into its instruction register (IR) and steps through up to four time steps (T0–T3). In each step it drives the register-file load and output enables, the ALU strobes and the bus-source select. Two internal 3-to-8 one-hot decoders expand the IR register fields XXX and YYY into the per-register Rin/Rout enables. The datapath registers, ALU and bus multiplexer consume these outputs directly.

## Interface
Parameters: none. Widths are fixed by the 9-bit instruction format III XXX YYY, with register count 8.

Ports (clock and reset first):
- Clock  in  1  — system clock; all state updates on rising edge. This block has one clock and uses a synchronous, active-high reset.
- Reset  in  1  — synchronous, active-high. Sampled on the rising edge of Clock.
- Run  in  1  — start request; sampled only in T0.
- DIN  in  9  — instruction word in T0; immediate data in T1 for mvi.
- IRin  out  1  — IR load strobe.
- Rin  out  [0:7]  — register load enables, one-hot. Bit 0 = R0.
- Rout  out  [0:7]  — register bus-drive enables, one-hot. Bit 0 = R0.
- Ain  out  1  — ALU A-register load.
- Gin  out  1  — ALU G-register load.
- Gout  out  1  — G drives bus.
- DINout  out  1  — DIN drives bus.
- AddSub  out  1  — 0 = add, 1 = subtract.
- Done  out  1  — final step of the current instruction.

## Operation
- State:
  - Tstep: 2-bit counter, T0..T3.
  - IR: 9-bit register, loaded from DIN on the rising edge of Clock when IRin=1.
- All control outputs are combinational functions of Tstep, IR and Run. All are 0 unless listed below.
- Decoding: X = IR[5:3], Y = IR[2:0]. Rin/Rout carry the one-hot image of X or Y. X=000 gives 10000000; X=111 gives 00000001.
- T0: IRin = Run. If Run=1, go to T1; otherwise stay in T0.
- Opcode IR[8:6] behaviour:
  - 000, mv Rx,Ry:
    - T1: Rout=dec(Y), Rin=dec(X), Done.
  - 001, mvi Rx,#D:
    - T1: DINout, Rin=dec(X), Done.
  - 010, add Rx,Ry:
    - T1: Rout=dec(X), Ain.
    - T2: Rout=dec(Y), Gin, AddSub=0.
    - T3: Gout, Rin=dec(X), Done.
  - 011, sub Rx,Ry: same as add, but AddSub=1 in T2.
  - 1xx, reserved: NOP. T1: Done only, no enables.
- Done=1 forces next Tstep=T0. Otherwise Tstep increments.
- Bus-source invariant: at most one of {any Rout bit, Gout, DINout} is high in any cycle.
- Run is ignored outside T0.

## Timing
- Reset=1 at a rising edge:
  - next state is Tstep=T0, IR=9'b0.
  - While Reset is high, all outputs are forced to 0, including IRin regardless of Run.
- After reset, the first instruction loads on the first edge with Run=1 and Reset=0.
- Latency, counted as cycles from the T0 cycle with Run=1 through the Done cycle inclusive:
  - mv, mvi and NOP: 2 cycles.
  - add and sub: 4 cycles.
- Back-to-back execution: the cycle after Done is T0. If Run=1 there, the next instruction loads with no bubble.
- DIN must hold the instruction during T0 and the immediate value during T1 of mvi.
- Reset asserted mid-instruction, in any of T1–T3:
  - instruction is aborted.
  - next cycle is T0 with all outputs 0.
  - no Done pulse for the aborted instruction.
- Reset and Run high in the same cycle: Reset wins. No IR load, Tstep=T0.
- Tstep never reaches T3 except for add/sub. The counter never wraps from T3 to T0 without Done.

## Test plan
- Reset, then idle: hold Reset=1 for 2 cycles, then Run=0 for 5 cycles → all outputs 0; Tstep stays T0; IRin=0.
- mvi R0,#5:
  - stimulus: Run=1, DIN=9'b001000000 in T0, then DIN=9'd5 in T1.
  - response: T0 IRin=1. T1 DINout=1, Rin=10000000, Done=1, Rout=0.
- mv R7,R3, IR=9'b000111011 → T1 Rout=00010000, Rin=00000001, Done=1.
- add R1,R2, IR=9'b010001010:
  - T1 Rout=01000000, Ain=1.
  - T2 Rout=00100000, Gin=1, AddSub=0.
  - T3 Gout=1, Rin=01000000, Done=1.
  - sub R1,R2 gives the identical sequence with AddSub=1 in T2.
- Back-to-back, Run held 1:
  - stimulus: sub followed by mv with no idle cycle.
  - response: IRin=1 in the cycle after sub's Done. Total 6 cycles from first T0 to the second Done.
  - every cycle: at most one bus source.
- Abort and reserved opcode:
  - Reset=1 during T2 of add → next cycle T0, no Done, no Gout.
  - Opcode 9'b101000000 → T1 Done=1 only; Rin=Rout=0.

Source files
------------

// File: rtl/proc_ctrl.sv
// Control-unit sequencer for the simple 9-bit processor.
// Latches an instruction into IR during T0, then walks T1..T3 driving
// register-file enables, ALU strobes and the bus-source select.
module proc_ctrl (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] DIN,
    output logic       IRin,
    output logic [0:7] Rin,
    output logic [0:7] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       DINout,
    output logic       AddSub,
    output logic       Done
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [1:0] tStep_q, tStep_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [0:7] decX, decY;

    // One-hot image of a register field; index 0 (leftmost bit) is R0.
    function automatic logic [0:7] dec3to8(input logic [2:0] sel);
        logic [0:7] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

    assign opcode = ir_q[8:6];
    assign decX   = dec3to8(ir_q[5:3]);
    assign decY   = dec3to8(ir_q[2:0]);

    // Control outputs: pure function of the step, IR and Run; held low under reset.
    always_comb begin
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (!Reset) begin
            case (tStep_q)
                T0: begin
                    IRin = Run;
                end
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            Rout = decY;
                            Rin  = decX;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = decX;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout = decX;
                            Ain  = 1'b1;
                        end
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        Rout   = decY;
                        Gin    = 1'b1;
                        AddSub = (opcode == OP_SUB);
                    end
                end
                T3: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        Gout = 1'b1;
                        Rin  = decX;
                        Done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next step and IR contents: Done returns to T0, otherwise advance; IR loads on IRin.
    always_comb begin
        tStep_d = tStep_q;
        ir_d    = ir_q;
        if (IRin) begin
            ir_d = DIN;
        end
        if (tStep_q == T0) begin
            tStep_d = Run ? T1 : T0;
        end else if (Done || tStep_q == T3) begin
            tStep_d = T0;
        end else begin
            tStep_d = tStep_q + 2'd1;
        end
    end

    // State registers with synchronous reset to T0 and a cleared IR.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tStep_q <= T0;
            ir_q    <= 9'b0;
        end else begin
            tStep_q <= tStep_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed testbench for proc_ctrl: each cycle's control vector is compared
// against a hand-written expectation, plus a bus-source exclusivity check.
module tb_proc_ctrl;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] DIN;
    logic       IRin;
    logic [0:7] Rin;
    logic [0:7] Rout;
    logic       Ain, Gin, Gout, DINout, AddSub, Done;

    int checks   = 0;
    int failures = 0;

    proc_ctrl dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .DIN    (DIN),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Packs an expected control vector in the same order as the observed one.
    function automatic logic [22:0] mk(input logic irin, input logic [0:7] rin,
                                       input logic [0:7] rout, input logic ain,
                                       input logic gin, input logic gout,
                                       input logic dinout, input logic addsub,
                                       input logic done);
        return {irin, rin, rout, ain, gin, gout, dinout, addsub, done};
    endfunction

    localparam logic [22:0] ZERO = 23'b0;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [22:0] observed,
                               input logic [22:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%06h expected=%06h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs after the falling edge, checks the
    // combinational outputs before the next rising edge, then lets it pass.
    task automatic applyStimulus(input string tag, input logic rst, input logic run,
                                 input logic [8:0] din, input logic [22:0] expected);
        logic [22:0] observed;
        int          sources;
        @(negedge Clock);
        Reset = rst;
        Run   = run;
        DIN   = din;
        #1;
        observed = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};
        checkOutput(tag, observed, expected);
        sources = $countones(Rout) + int'(Gout) + int'(DINout);
        checkOutput({tag, "_bus"}, {22'b0, (sources <= 1)}, 23'd1);
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = 9'b0;

        // Reset held two cycles; Run high in the second must not raise IRin.
        applyStimulus("rst0", 1'b1, 1'b0, 9'b001000000, ZERO);
        applyStimulus("rst1_run", 1'b1, 1'b1, 9'b001000000, ZERO);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("idle", 1'b0, 1'b0, 9'b010001010, ZERO);
        end

        // mvi R0,#5
        applyStimulus("mvi_t0", 1'b0, 1'b1, 9'b001000000,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("mvi_t1", 1'b0, 1'b0, 9'd5,
                      mk(0, 8'b10000000, 8'b0, 0, 0, 0, 1, 0, 1));
        applyStimulus("mvi_after", 1'b0, 1'b0, 9'd0, ZERO);

        // mv R7,R3
        applyStimulus("mv_t0", 1'b0, 1'b1, 9'b000111011,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("mv_t1", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b00000001, 8'b00010000, 0, 0, 0, 0, 0, 1));

        // add R1,R2
        applyStimulus("add_t0", 1'b0, 1'b1, 9'b010001010,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("add_t1", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b0, 8'b01000000, 1, 0, 0, 0, 0, 0));
        applyStimulus("add_t2", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b0, 8'b00100000, 0, 1, 0, 0, 0, 0));
        applyStimulus("add_t3", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b01000000, 8'b0, 0, 0, 1, 0, 0, 1));
        applyStimulus("add_after", 1'b0, 1'b0, 9'd0, ZERO);

        // sub R1,R2 then mv R2,R5 back-to-back with Run held high.
        applyStimulus("sub_t0", 1'b0, 1'b1, 9'b011001010,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("sub_t1", 1'b0, 1'b1, 9'b111111111,
                      mk(0, 8'b0, 8'b01000000, 1, 0, 0, 0, 0, 0));
        applyStimulus("sub_t2", 1'b0, 1'b1, 9'b111111111,
                      mk(0, 8'b0, 8'b00100000, 0, 1, 0, 0, 1, 0));
        applyStimulus("sub_t3", 1'b0, 1'b1, 9'b111111111,
                      mk(0, 8'b01000000, 8'b0, 0, 0, 1, 0, 0, 1));
        applyStimulus("b2b_mv_t0", 1'b0, 1'b1, 9'b000010101,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("b2b_mv_t1", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b00100000, 8'b00000100, 0, 0, 0, 0, 0, 1));

        // add aborted by Reset during T2: no Gout, no Done afterwards.
        applyStimulus("abort_t0", 1'b0, 1'b1, 9'b010001010,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("abort_t1", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b0, 8'b01000000, 1, 0, 0, 0, 0, 0));
        applyStimulus("abort_t2_rst", 1'b1, 1'b0, 9'd0, ZERO);
        applyStimulus("abort_next", 1'b0, 1'b0, 9'd0, ZERO);
        applyStimulus("abort_next2", 1'b0, 1'b0, 9'd0, ZERO);

        // Reserved opcode: Done only in T1.
        applyStimulus("nop_t0", 1'b0, 1'b1, 9'b101000000,
                      mk(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
        applyStimulus("nop_t1", 1'b0, 1'b0, 9'd0,
                      mk(0, 8'b0, 8'b0, 0, 0, 0, 0, 0, 1));
        applyStimulus("nop_after", 1'b0, 1'b0, 9'd0, ZERO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
